// File: rtl/act_ram_stream_ctrl_pkg.sv
// rtl/act_ram_stream_ctrl_pkg.sv - shared helpers and arbitration constants for act_ram_stream_ctrl
package act_ram_stream_ctrl_pkg;

  typedef enum logic {
    PRIO_WRITE = 1'b0,
    PRIO_READ  = 1'b1
  } prio_e;

  // Ceiling log2, never below 1 so a depth-1 memory still gets an address bit.
  function automatic int C_LOG_2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/act_skid_buf2.sv
// rtl/act_skid_buf2.sv - 2-entry skid buffer absorbing the SRAM read return
module act_skid_buf2 #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             pop;

  assign out_valid = (cnt != 2'd0);
  assign out_data  = head;
  assign count     = cnt;
  assign pop       = out_valid && out_ready;

  // The producer guarantees room, so a push never meets a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_data;
          else             tail <= in_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/act_ram_stream_ctrl.sv
// rtl/act_ram_stream_ctrl.sv - single-port activation SRAM run as a circular stream FIFO
// ACT_RAM_CTRL_STAT_EN adds stat_max_level and stat_stall_cnt outputs.
module act_ram_stream_ctrl
  import act_ram_stream_ctrl_pkg::*;
#(
  parameter int SRAM_WIDTH = 128,
  parameter int SRAM_WORD  = 64,
  parameter int ADDR_BITS  = C_LOG_2(SRAM_WORD)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SRAM_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SRAM_WIDTH-1:0] out_data,
  output logic [ADDR_BITS-1:0]  ram_addr_w,
  output logic [ADDR_BITS-1:0]  ram_addr_r,
  output logic                  ram_write_en,
  output logic                  ram_read_en,
  output logic [SRAM_WIDTH-1:0] ram_data_in,
  input  logic [SRAM_WIDTH-1:0] ram_data_out,
  output logic [ADDR_BITS:0]    level
`ifdef ACT_RAM_CTRL_STAT_EN
  ,
  output logic [ADDR_BITS:0]    stat_max_level,
  output logic [15:0]           stat_stall_cnt
`endif
);

  localparam logic [ADDR_BITS:0]   DEPTH = (ADDR_BITS+1)'(SRAM_WORD);
  localparam logic [ADDR_BITS-1:0] LAST  = ADDR_BITS'(SRAM_WORD - 1);

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   sram_cnt;
  logic                 inflight;
  prio_e                rr_prio;
  logic [1:0]           skid_cnt;
  logic                 halt;
  logic                 pop;
  logic                 rd_need;
  logic                 wr_fire;
  logic                 rd_fire;

  assign halt = rst || flush;
  assign pop  = out_valid && out_ready;

  // An entry leaving the skid buffer this cycle already counts as free room.
  assign rd_need = (sram_cnt != '0) &&
                   (({1'b0, skid_cnt - {1'b0, pop}} + {2'b00, inflight}) < 3'd2);

  assign in_ready = !halt && (sram_cnt < DEPTH) && !(rd_need && rr_prio == PRIO_READ);
  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = !halt && rd_need && !wr_fire;

  assign ram_write_en = wr_fire;
  assign ram_read_en  = rd_fire;
  assign ram_addr_w   = wr_ptr;
  assign ram_addr_r   = rd_ptr;
  assign ram_data_in  = wr_fire ? in_data : '0;

  assign level = sram_cnt + (ADDR_BITS+1)'(inflight) + (ADDR_BITS+1)'(skid_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
      rr_prio  <= PRIO_WRITE;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_BITS'(1);
      if (rd_fire) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_BITS'(1);
      if (wr_fire)      sram_cnt <= sram_cnt + (ADDR_BITS+1)'(1);
      else if (rd_fire) sram_cnt <= sram_cnt - (ADDR_BITS+1)'(1);
      inflight <= rd_fire;
      if (in_valid && rd_need) rr_prio <= (rr_prio == PRIO_WRITE) ? PRIO_READ : PRIO_WRITE;
    end
  end

  act_skid_buf2 #(
    .WIDTH(SRAM_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .in_valid (inflight),
    .in_data  (ram_data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (skid_cnt)
  );

`ifdef ACT_RAM_CTRL_STAT_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stat_max_level <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (level > stat_max_level) stat_max_level <= level;
      if (in_valid && !in_ready && stat_stall_cnt != 16'hFFFF)
        stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_ram_stream_ctrl.sv
// tb/tb_act_ram_stream_ctrl.sv - randomized self-checking bench for act_ram_stream_ctrl
`timescale 1ns/1ps
module tb_act_ram_stream_ctrl;

  localparam int W     = 32;
  localparam int DEPTH = 49;
  localparam int AB    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [AB-1:0] ram_addr_w;
  logic [AB-1:0] ram_addr_r;
  logic          ram_write_en;
  logic          ram_read_en;
  logic [W-1:0]  ram_data_in;
  logic [W-1:0]  ram_data_out = '0;
  logic [AB:0]   level;
`ifdef ACT_RAM_CTRL_STAT_EN
  logic [AB:0]   stat_max_level;
  logic [15:0]   stat_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit alt_phase = 1'b0;
  int rd_pulses = 0;

  logic [W-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  // Wrapper stand-in: one-cycle registered read.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  ram_data_out    <= mem[ram_addr_r];
  end

  act_ram_stream_ctrl #(
    .SRAM_WIDTH(W),
    .SRAM_WORD (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .ram_addr_w  (ram_addr_w),
    .ram_addr_r  (ram_addr_r),
    .ram_write_en(ram_write_en),
    .ram_read_en (ram_read_en),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out),
    .level       (level)
`ifdef ACT_RAM_CTRL_STAT_EN
    ,
    .stat_max_level(stat_max_level),
    .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ceq(input string name, input longint act, input longint exp);
    chk(act == exp, name, act, exp);
  endtask

  // Reference: data queue of accepted-but-unpopped words, split into words still in
  // the SRAM and words already read out of it.
  logic [W-1:0] q[$];
  int m_sram = 0;
  int m_buf  = 0;
  int m_wptr = 0;
  int m_rptr = 0;
  int m_stall = 0;
  int m_max = 0;

  always @(negedge clk) begin
    bit pop_now;
    pop_now = out_valid && out_ready;
    if (rst) begin
      ceq("rst_in_ready", in_ready, 0);
      ceq("rst_wr_en", ram_write_en, 0);
      ceq("rst_rd_en", ram_read_en, 0);
      q.delete();
      m_sram = 0; m_buf = 0; m_wptr = 0; m_rptr = 0;
      m_stall = 0; m_max = 0; rd_pulses = 0;
    end else begin
      ceq("level", level, q.size());
      ceq("wr_en_rule", ram_write_en, in_valid && in_ready);
      chk(!(ram_write_en && ram_read_en), "single_port", {ram_write_en, ram_read_en}, 0);
      if (flush) begin
        ceq("flush_in_ready", in_ready, 0);
        ceq("flush_rd_en", ram_read_en, 0);
      end
      if (m_sram == DEPTH) ceq("full_in_ready", in_ready, 0);
      if (ram_write_en) begin
        ceq("addr_w", ram_addr_w, m_wptr);
        ceq("data_in", ram_data_in, in_data);
      end
      if (ram_read_en) begin
        ceq("addr_r", ram_addr_r, m_rptr);
        chk(m_sram > 0, "rd_when_empty", m_sram, 1);
        chk((m_buf - (pop_now ? 1 : 0)) < 2, "rd_no_room", m_buf - (pop_now ? 1 : 0), 1);
        rd_pulses++;
      end
      if (pop_now) begin
        if (q.size() == 0) chk(1'b0, "pop_when_empty", 1, 0);
        else ceq("out_data", out_data, q[0]);
      end
      if (alt_phase && in_valid)
        chk(ram_write_en ^ ram_read_en, "one_access", {ram_write_en, ram_read_en}, 1);
`ifdef ACT_RAM_CTRL_STAT_EN
      ceq("stat_max", stat_max_level, m_max);
      ceq("stat_stall", stat_stall_cnt, m_stall);
`endif
      if (flush) begin
        q.delete();
        m_sram = 0; m_buf = 0; m_wptr = 0; m_rptr = 0;
        m_stall = 0; m_max = 0;
      end else begin
        if (in_valid && !in_ready && m_stall < 65535) m_stall++;
        if (int'(level) > m_max) m_max = int'(level);
        if (ram_write_en) begin
          q.push_back(in_data);
          m_wptr = (m_wptr + 1) % DEPTH;
          m_sram++;
        end
        if (ram_read_en) begin
          m_rptr = (m_rptr + 1) % DEPTH;
          m_sram--;
          m_buf++;
        end
        if (pop_now && q.size() > 0) begin
          void'(q.pop_front());
          m_buf--;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, output logic hs);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    hs = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    logic hs;
    int g;
    g = 0;
    while (level != 0 && g < 200) begin
      drive(1'b0, '0, 1'b1, hs);
      g++;
    end
    ceq(name, level, 0);
  endtask

  initial begin
    logic         hs;
    int           idx;
    int           guard;
    logic [W-1:0] word;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    ceq("reset_in_ready", in_ready, 1);
    ceq("reset_out_valid", out_valid, 0);
    ceq("reset_level", level, 0);
    ceq("reset_wr_en", ram_write_en, 0);
    ceq("reset_rd_en", ram_read_en, 0);
    ceq("reset_addr_w", ram_addr_w, 0);
    ceq("reset_addr_r", ram_addr_r, 0);
    ceq("reset_data_in", ram_data_in, 0);
    @(posedge clk); #1;

    // Three words with the output stalled.
    idx = 0; guard = 0;
    while (idx < 3 && guard < 40) begin
      drive(1'b1, W'(32'hA0 + idx), 1'b0, hs);
      if (hs) idx++;
      guard++;
    end
    ceq("a_sent", idx, 3);
    repeat (6) drive(1'b0, '0, 1'b0, hs);
    ceq("a_level", level, 3);
    ceq("a_out_valid", out_valid, 1);
    ceq("a_head", out_data, 32'hA0);
    ceq("a_rd_pulses", rd_pulses, 2);
    drain("a_drain");

    // Latency into an empty block.
    drive(1'b1, 32'h55, 1'b0, hs);
    ceq("lat_hs", hs, 1);
    in_valid = 1'b0; #1;
    ceq("lat_rd_issue", ram_read_en, 1);
    ceq("lat_valid_n1", out_valid, 0);
    @(posedge clk); #1;
    ceq("lat_valid_n2", out_valid, 0);
    @(posedge clk); #1;
    ceq("lat_valid_n3", out_valid, 1);
    ceq("lat_data", out_data, 32'h55);
    drain("lat_drain");

    // Flush with a read in flight.
    drive(1'b1, 32'h77, 1'b0, hs);
    ceq("fl_hs", hs, 1);
    in_valid = 1'b0; #1;
    ceq("fl_rd_issue", ram_read_en, 1);
    @(posedge clk); #1;
    flush = 1'b1; #1;
    ceq("fl_in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; #1;
    ceq("fl_out_valid", out_valid, 0);
    ceq("fl_level", level, 0);
    @(posedge clk); #1;
    ceq("fl_out_valid2", out_valid, 0);
    in_valid = 1'b1; in_data = 32'h88; #1;
    ceq("fl_restart_wr", ram_write_en, 1);
    ceq("fl_restart_addr", ram_addr_w, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("fl_drain");

    // Fill to capacity and drain, twice, crossing the pointer wrap.
    for (int p = 0; p < 2; p++) begin
      idx = 0; guard = 0; word = $urandom;
      while (idx < DEPTH + 2 && guard < 400) begin
        drive(1'b1, word, 1'b0, hs);
        if (hs) begin idx++; word = $urandom; end
        guard++;
      end
      ceq("fill_cnt", idx, DEPTH + 2);
      drive(1'b1, word, 1'b0, hs);
      ceq("fill_blocked", hs, 0);
      ceq("fill_level", level, DEPTH + 2);
      in_valid = 1'b0;
      drain("fill_drain");
    end

    // Sustained conflict: one access per cycle.
    alt_phase = 1'b1;
    idx = 0; guard = 0; word = $urandom;
    while (idx < 500 && guard < 2000) begin
      drive(1'b1, word, 1'b1, hs);
      if (hs) begin idx++; word = $urandom; end
      guard++;
    end
    alt_phase = 1'b0;
    ceq("stream_cnt", idx, 500);
    drain("stream_drain");

    // Random valid and backpressure.
    idx = 0; guard = 0; word = $urandom;
    while ((idx < 1000 || level != 0) && guard < 20000) begin
      drive((idx < 1000) && ($urandom_range(0, 9) < 7), word, $urandom_range(0, 9) >= 3, hs);
      if (hs) begin idx++; word = $urandom; end
      guard++;
    end
    ceq("rand_cnt", idx, 1000);
    ceq("rand_level", level, 0);

`ifdef ACT_RAM_CTRL_STAT_EN
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, hs);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, W'(32'hC0 + k), 1'b0, hs);
      ceq("st_iso_hs", hs, 1);
      repeat (4) drive(1'b0, '0, 1'b0, hs);
    end
    idx = 0;
    for (int k = 0; k < 58; k++) begin
      drive(1'b1, W'(32'hD0 + k), 1'b0, hs);
      if (hs) idx++;
    end
    in_valid = 1'b0; #1;
    ceq("st_writes", idx, 48);
    ceq("st_stall_lit", stat_stall_cnt, 10);
    ceq("st_max_lit", stat_max_level, DEPTH + 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; #1;
    ceq("st_flush_stall", stat_stall_cnt, 0);
    ceq("st_flush_max", stat_max_level, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
